// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: register map, CTRL bit
// positions, FSM state encoding and the DUTY reset value.
package led_seq_pkg;

  // Register addresses
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_DUTY    = 2'd3;

  // CTRL bit positions
  localparam int CTRL_MANUAL = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_REPEAT = 2;
  localparam int CTRL_START  = 3;
  localparam int CTRL_BUSY   = 4;

  // DUTY reset value: fully on, so PWM gating is transparent after reset
  localparam logic [7:0] DUTY_RESET = 8'hFF;

  // Pattern engine state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: counts 0..PRESCALE-1 while enabled and raises a
// one-cycle tick on the terminal count. Dropping enable for one cycle
// returns the count to 0, which is how the sequencer restarts a step.
module led_seq_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;

  // Count while enabled, wrap on terminal count, hold at 0 otherwise
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = enable && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/led_sequencer.sv
// Status LED controller: manual level or an 8-step pattern played at a
// programmable step rate, once or repeating, behind a cs/write register bus.
// Optional PWM brightness gating is built when LED_SEQ_PWM_EN is defined;
// without it, address 3 reads 0 and ignores writes.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       write,
  input  logic [1:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       led
);

  // Programmer-visible registers
  logic       manual_reg;
  logic       mode_reg;
  logic       repeat_reg;
  logic [7:0] pattern_reg;
  logic [7:0] period_reg;

  // Pattern engine state
  state_t     state_reg, state_next;
  logic [2:0] index_reg, index_next;
  logic [7:0] step_cnt_reg, step_cnt_next;

  logic       led_reg;
  logic       led_source;
  logic       led_gate;

  // Bus decode
  logic ctrl_wr, pattern_wr, period_wr;
  logic restart_req, abort_req;
  logic pre_enable, pre_tick;

  assign ctrl_wr    = cs && write && (address == ADDR_CTRL);
  assign pattern_wr = cs && write && (address == ADDR_PATTERN);
  assign period_wr  = cs && write && (address == ADDR_PERIOD);

  // START only counts when the same write also selects pattern mode;
  // any CTRL write that clears MODE aborts a running pattern.
  assign restart_req = ctrl_wr && data_in[CTRL_MODE] && data_in[CTRL_START];
  assign abort_req   = ctrl_wr && !data_in[CTRL_MODE];

  // Prescaler runs only in RUN; a start or abort clears it on that edge
  assign pre_enable = (state_reg == ST_RUN) && !restart_req && !abort_req;

  led_seq_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(pre_enable),
    .tick  (pre_tick)
  );

  // Register file writes (START is a strobe and is never stored)
  always_ff @(posedge clock) begin
    if (reset) begin
      manual_reg  <= 1'b0;
      mode_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
      pattern_reg <= 8'h00;
      period_reg  <= 8'h00;
    end else begin
      if (ctrl_wr) begin
        manual_reg <= data_in[CTRL_MANUAL];
        mode_reg   <= data_in[CTRL_MODE];
        repeat_reg <= data_in[CTRL_REPEAT];
      end
      if (pattern_wr) begin
        pattern_reg <= data_in;
      end
      if (period_wr) begin
        period_reg <= data_in;
      end
    end
  end

  // FSM state, step index and step counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      index_reg    <= 3'd0;
      step_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      index_reg    <= index_next;
      step_cnt_reg <= step_cnt_next;
    end
  end

  // Next-state logic: start/restart, abort, and step advance on prescaler tick
  always_comb begin
    state_next    = state_reg;
    index_next    = index_reg;
    step_cnt_next = step_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (restart_req) begin
          state_next    = ST_RUN;
          index_next    = 3'd0;
          step_cnt_next = 8'd0;
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_next    = ST_IDLE;
          index_next    = 3'd0;
          step_cnt_next = 8'd0;
        end else if (restart_req) begin
          index_next    = 3'd0;
          step_cnt_next = 8'd0;
        end else if (pre_tick) begin
          if (step_cnt_reg == period_reg) begin
            // End of step; the counter free-wraps at 255 if PERIOD was
            // lowered below the current count mid-step.
            step_cnt_next = 8'd0;
            index_next    = index_reg + 3'd1;
            if (index_reg == 3'd7 && !repeat_reg) begin
              state_next = ST_IDLE;
            end
          end else begin
            step_cnt_next = step_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        index_next    = 3'd0;
        step_cnt_next = 8'd0;
      end
    endcase
  end

  // LED source: pattern bit while running, else manual level (0 in pattern mode)
  always_comb begin
    led_source = 1'b0;
    if (state_reg == ST_RUN) begin
      led_source = pattern_reg[index_reg];
    end else if (!mode_reg) begin
      led_source = manual_reg;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [7:0] duty_reg;
  logic [7:0] pwm_cnt_reg;

  // DUTY register and free-running PWM counter
  always_ff @(posedge clock) begin
    if (reset) begin
      duty_reg    <= DUTY_RESET;
      pwm_cnt_reg <= 8'd0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      if (cs && write && (address == ADDR_DUTY)) begin
        duty_reg <= data_in;
      end
    end
  end

  // 255 is treated as fully on rather than 255/256
  assign led_gate = (pwm_cnt_reg < duty_reg) || (duty_reg == 8'hFF);
`else
  assign led_gate = 1'b1;
`endif

  // Output register for the LED pin
  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg <= 1'b0;
    end else begin
      led_reg <= led_source && led_gate;
    end
  end

  assign led = led_reg;

  // Combinational read mux, zero when not selected
  always_comb begin
    data_out = 8'h00;
    if (cs) begin
      case (address)
        ADDR_CTRL: begin
          data_out[CTRL_MANUAL] = manual_reg;
          data_out[CTRL_MODE]   = mode_reg;
          data_out[CTRL_REPEAT] = repeat_reg;
          data_out[CTRL_BUSY]   = (state_reg == ST_RUN);
        end
        ADDR_PATTERN: data_out = pattern_reg;
        ADDR_PERIOD:  data_out = period_reg;
`ifdef LED_SEQ_PWM_EN
        ADDR_DUTY:    data_out = duty_reg;
`else
        ADDR_DUTY:    data_out = 8'h00;
`endif
        default:      data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer with PRESCALE = 4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_led_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cs;
  logic       write;
  logic [1:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       led;

  int checks = 0;
  int errors = 0;

  led_sequencer #(
    .PRESCALE(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .cs      (cs),
    .write   (write),
    .address (address),
    .data_in (data_in),
    .data_out(data_out),
    .led     (led)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; write = 1'b1; address = a; data_in = d;
    tick();
    cs = 1'b0; write = 1'b0; data_in = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; write = 1'b0; address = a;
    #1;
    d = data_out;
    cs = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] pat;
    logic [7:0] exp_duty;
    int         ones;

`ifdef LED_SEQ_PWM_EN
    exp_duty = 8'hFF;
`else
    exp_duty = 8'h00;
`endif
    pat = 8'hA5;

    reset = 1'b1; cs = 1'b0; write = 1'b0; address = 2'd0; data_in = 8'h00;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("reset_led", {7'd0, led}, 8'h00);
    bus_read(2'd0, rd); check("reset_ctrl", rd, 8'h00);
    bus_read(2'd1, rd); check("reset_pattern", rd, 8'h00);
    bus_read(2'd2, rd); check("reset_period", rd, 8'h00);
    bus_read(2'd3, rd); check("reset_duty", rd, exp_duty);
    check("nocs_read", data_out, 8'h00);

    // Manual mode: one register stage between write and led
    bus_write(2'd0, 8'h01);
    check("manual_lag", {7'd0, led}, 8'h00);
    tick();
    check("manual_on", {7'd0, led}, 8'h01);
    bus_read(2'd0, rd); check("manual_ctrl", rd, 8'h01);

    // One-shot: PATTERN A5, PERIOD 1 -> 8 clocks per step, 64 total
    bus_write(2'd1, 8'hA5);
    bus_write(2'd2, 8'h01);
    bus_read(2'd1, rd); check("pattern_rd", rd, 8'hA5);
    bus_read(2'd2, rd); check("period_rd", rd, 8'h01);
    bus_write(2'd0, 8'h0A);
    bus_read(2'd0, rd); check("oneshot_busy0", rd, 8'h12);
    for (int c = 0; c < 64; c++) begin
      tick();
      check($sformatf("oneshot_led%0d", c), {7'd0, led}, {7'd0, pat[c/8]});
      bus_read(2'd0, rd);
      check($sformatf("oneshot_busy%0d", c), rd & 8'h10, (c < 63) ? 8'h10 : 8'h00);
    end
    tick();
    check("oneshot_end_led", {7'd0, led}, 8'h00);
    bus_read(2'd0, rd); check("oneshot_end_ctrl", rd, 8'h02);

    // Repeat: pattern wraps seamlessly past clock 64
    bus_write(2'd0, 8'h0E);
    for (int c = 0; c < 80; c++) begin
      tick();
      check($sformatf("repeat_led%0d", c), {7'd0, led}, {7'd0, pat[(c/8)%8]});
      bus_read(2'd0, rd);
      check($sformatf("repeat_busy%0d", c), rd & 8'h10, 8'h10);
    end
    // Abort into manual on
    bus_write(2'd0, 8'h01);
    bus_read(2'd0, rd); check("abort_ctrl", rd, 8'h01);
    tick();
    check("abort_led", {7'd0, led}, 8'h01);

    // Restart during step 3
    bus_write(2'd0, 8'h0E);
    for (int c = 0; c < 27; c++) tick();
    check("step3_led", {7'd0, led}, {7'd0, pat[3]});
    bus_write(2'd0, 8'h0E);
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("restart_led%0d", c), {7'd0, led}, {7'd0, pat[0]});
    end
    tick();
    check("restart_step1", {7'd0, led}, {7'd0, pat[1]});

    // Live PATTERN update mid-step
    bus_write(2'd1, 8'hFF);
    check("live_lag", {7'd0, led}, 8'h00);
    tick();
    check("live_led", {7'd0, led}, 8'h01);

    // Reset mid-pattern, with a simultaneous CTRL write that must lose
    for (int c = 0; c < 5; c++) tick();
    check("prereset_led", {7'd0, led}, 8'h01);
    reset = 1'b1; cs = 1'b1; write = 1'b1; address = 2'd0; data_in = 8'h01;
    tick();
    reset = 1'b0; cs = 1'b0; write = 1'b0; data_in = 8'h00;
    check("midreset_led", {7'd0, led}, 8'h00);
    bus_read(2'd0, rd); check("midreset_ctrl", rd, 8'h00);
    bus_read(2'd1, rd); check("midreset_pattern", rd, 8'h00);
    bus_read(2'd2, rd); check("midreset_period", rd, 8'h00);
    bus_read(2'd3, rd); check("midreset_duty", rd, exp_duty);
    tick();
    check("postreset_led", {7'd0, led}, 8'h00);

`ifdef LED_SEQ_PWM_EN
    // PWM brightness in manual-on mode
    bus_write(2'd0, 8'h01);
    bus_write(2'd3, 8'h40);
    tick();
    ones = 0;
    for (int c = 0; c < 256; c++) begin tick(); ones += int'(led); end
    check("pwm_duty64", 8'(ones), 8'd64);
    bus_write(2'd3, 8'h00);
    tick();
    ones = 0;
    for (int c = 0; c < 256; c++) begin tick(); ones += int'(led); end
    check("pwm_duty0", 8'(ones), 8'd0);
    bus_write(2'd3, 8'hFF);
    tick();
    ones = 0;
    for (int c = 0; c < 256; c++) begin tick(); ones += int'(led); end
    check("pwm_duty255_lo", 8'(ones), 8'd0);
    check("pwm_duty255_hi", 8'(ones >> 8), 8'd1);
`else
    // Without PWM, address 3 ignores writes
    bus_write(2'd3, 8'h40);
    bus_read(2'd3, rd); check("duty_ignored", rd, 8'h00);
    ones = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Bus-programmable controller for the board status LED. It replaces direct CPU bit-banging with a hardware pattern engine. In manual mode the CPU sets the LED level directly. In pattern mode an 8-step on/off pattern is played out at a programmable step rate, either once or repeating. It sits on the same chip-select/write register bus as the other MAXI030 core peripherals and drives the LED pin directly.

## Interface
- PRESCALE, default 1000, clocks per prescaler tick (≥1)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- cs  in  1  block select
- write  in  1  1 = write cycle, 0 = read cycle (qualified by cs)
- address  in  2  register select
- data_in  in  8  write data
- data_out  out  8  read data, combinational mux of address, 0 when !cs
- led  out  1  LED drive, registered

## Operation
- Registers, written on a clock edge with cs && write:
  - 0 CTRL:
    - bit0 MANUAL (LED level in manual mode)
    - bit1 MODE (0 manual, 1 pattern)
    - bit2 REPEAT
    - bit3 START (write-1 strobe, never stored, reads 0)
    - bit4 BUSY (read-only, 1 in RUN)
    - bits7:5 read 0
  - 1 PATTERN: bit n is the LED level for step n.
  - 2 PERIOD: step length = (PERIOD+1)·PRESCALE clocks.
  - 3 DUTY: see Configuration.
- Reset values:
  - CTRL 0, PATTERN 0, PERIOD 0, DUTY 8'hFF
  - state IDLE, step index 0, counters 0
  - led 0
- FSM states: IDLE, RUN.
  - IDLE→RUN: CTRL write with START=1 and MODE=1 in the written data. Index, step counter and prescaler are cleared.
  - RUN, end of step: when a prescaler tick coincides with step counter == PERIOD, the index increments. Stepping off index 7 wraps to 0 if REPEAT=1; otherwise the FSM goes to IDLE.
  - RUN→IDLE: any CTRL write with MODE=0 (abort). Takes effect on that edge.
  - START while in RUN: restart from index 0 with counters cleared.
  - START with MODE=0: ignored.
- LED source:
  - In RUN: PATTERN[index].
  - Otherwise: MANUAL when MODE=0, and 0 when MODE=1.
  - led registers this source (subject to PWM gating when built in).
- PATTERN or PERIOD written during RUN takes effect immediately. Nothing is shadowed. If a new PERIOD is below the current step count, the step ends when the counter wraps at 255.

## Timing
- Register write at edge N → new led value visible after edge N+1 (one register stage).
- START at edge N → led = PATTERN[0] after edge N+1.
- Step k occupies exactly (PERIOD+1)·PRESCALE clocks.
- One-shot: total 8·(PERIOD+1)·PRESCALE clocks. BUSY drops on the edge ending step 7.
- Prescaler: counts 0..PRESCALE-1 and ticks on terminal count. It runs only in RUN; in IDLE it is held at 0.
- Reset has priority over every bus write, including mid-pattern: led = 0 after the reset edge.

## Configuration
- LED_SEQ_PWM_EN defined:
  - Adds a free-running 8-bit PWM counter.
  - Final led = source && (pwm_cnt < DUTY || DUTY == 8'hFF).
  - DUTY 0 = always off; DUTY 255 = always on.
  - DUTY is readable and writable.
- LED_SEQ_PWM_EN undefined:
  - No PWM logic.
  - Address 3 reads 0 and writes are ignored.
  - led = source.

## Structure
- led_seq_pkg:
  - register address constants (CTRL, PATTERN, PERIOD, DUTY)
  - CTRL bit-position constants
  - FSM state typedef (IDLE, RUN)
  - DUTY reset constant
- Sub-module led_seq_prescaler: parameter PRESCALE; inputs clock, reset, enable; output one-cycle tick. Holds its count at 0 when not enabled.

## Test plan
- Reset:
  - Assert reset during a running pattern → after edge: led = 0, all registers read 0 except DUTY (reads 8'hFF with PWM, 0 without).
- Manual mode:
  - Write CTRL = 8'h01 → led = 1 one cycle after the write.
  - Read CTRL → 8'h01.
- One-shot:
  - PRESCALE = 4, PERIOD = 1, PATTERN = 8'hA5, write CTRL = 8'h0A.
  - led sequence is 1,0,1,0,0,1,0,1 (bit0 first), each level for 8 clocks.
  - BUSY = 1 for 64 clocks, then led = 0 and BUSY = 0.
- Repeat:
  - As one-shot but CTRL = 8'h0E → pattern repeats seamlessly at clock 64.
  - Then write CTRL = 8'h01 mid-pattern → BUSY = 0 and led = 1 on the next cycle.
- Restart and live update:
  - START during step 3 → led = PATTERN[0] next cycle, and the step lasts a full 8 clocks.
  - Write PATTERN = 8'hFF mid-step → led = 1 on the next cycle.
- PWM (LED_SEQ_PWM_EN):
  - Manual on, DUTY = 64 → led high for 64 of every 256 clocks.
  - DUTY = 0 → led constantly 0.
  - DUTY = 255 → led constantly 1.
